// File: rtl/my_alu_pkg.sv
// Shared definitions for the my_alu datapath ALU: opcode encoding and width constants.
package my_alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_SUM     = 4'd0,
        OP_SUB     = 4'd1,
        OP_NEG_B   = 4'd2,
        OP_MULT    = 4'd3,
        OP_AND     = 4'd4,
        OP_OR      = 4'd5,
        OP_XOR     = 4'd6,
        OP_NOT_A   = 4'd7,
        OP_SHIFT_L = 4'd8,
        OP_SHIFT_R = 4'd9,
        OP_ASHR    = 4'd10,
        OP_PASS_A  = 4'd11
    } op_e;

endpackage

// File: rtl/my_alu_shifter.sv
// Combinational 2*LENGTH-bit barrel shifter for my_alu (SHIFT_L, SHIFT_R, ASHR).
// Shift distances of 2*LENGTH or more flush the operand completely: zeros for
// the logical shifts, copies of the sign bit for the arithmetic right shift.
module my_alu_shifter
    import my_alu_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic [LENGTH-1:0]   a,
    input  logic [LENGTH-1:0]   amount,
    input  logic [OP_W-1:0]     op,
    output logic [2*LENGTH-1:0] shifted
);

    localparam int W = 2 * LENGTH;

    logic [W-1:0]        zextA;
    logic signed [W-1:0] sextA;
    logic                outOfRange;
    logic [W-1:0]        shlRaw;
    logic [W-1:0]        shrRaw;
    logic [W-1:0]        ashrRaw;

    assign zextA      = {{LENGTH{1'b0}}, a};
    assign sextA      = {{LENGTH{a[LENGTH-1]}}, a};
    assign outOfRange = ({{W{1'b0}}, amount} >= (W + LENGTH)'(W));
    assign shlRaw     = zextA << amount;
    assign shrRaw     = zextA >> amount;
    assign ashrRaw    = sextA >>> amount;

    // Select the shift flavour and apply the saturation for oversized distances.
    always_comb begin
        shifted = '0;
        if (op == OP_SHIFT_L) begin
            shifted = outOfRange ? '0 : shlRaw;
        end else if (op == OP_SHIFT_R) begin
            shifted = outOfRange ? '0 : shrRaw;
        end else if (op == OP_ASHR) begin
            shifted = outOfRange ? {W{a[LENGTH-1]}} : ashrRaw;
        end
    end

endmodule

// File: rtl/my_alu.sv
// Registered integer ALU with a double-width result plus carry/overflow flags.
// Optional feature macro: MY_ALU_MULT_EN builds the signed multiplier for
// opcode 3; without it opcode 3 behaves like a reserved opcode.
module my_alu
    import my_alu_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [LENGTH-1:0]   A,
    input  logic [LENGTH-1:0]   B,
    input  logic [OP_W-1:0]     Control,
    output logic [2*LENGTH-1:0] Result,
    output logic                carry,
    output logic                overflow
);

    localparam int W   = 2 * LENGTH;
    localparam int MSB = LENGTH - 1;

    logic [W-1:0] sextA;
    logic [W-1:0] sextB;
    logic [W-1:0] zextA;
    logic [W-1:0] zextB;
    logic [W-1:0] sumW;
    logic [W-1:0] diffW;
    logic [W-1:0] negW;
    logic [W-1:0] shifted;

    // The low LENGTH bits of the wide sum/difference equal the narrow ones, so
    // the narrow carry out is rebuilt from the MSB column alone.
    logic sumCarryIn;
    logic sumCarryOut;
    logic diffCarryIn;
    logic diffCarryOut;
    logic bMsbInv;

    logic [W-1:0] resultNext;
    logic         carryNext;
    logic         overflowNext;

    assign sextA = {{LENGTH{A[MSB]}}, A};
    assign sextB = {{LENGTH{B[MSB]}}, B};
    assign zextA = {{LENGTH{1'b0}}, A};
    assign zextB = {{LENGTH{1'b0}}, B};

    assign sumW  = sextA + sextB;
    assign diffW = sextA - sextB;
    assign negW  = '0 - sextB;

    assign sumCarryIn   = sumW[MSB] ^ A[MSB] ^ B[MSB];
    assign sumCarryOut  = (A[MSB] & B[MSB]) | ((A[MSB] ^ B[MSB]) & sumCarryIn);
    assign bMsbInv      = ~B[MSB];
    assign diffCarryIn  = diffW[MSB] ^ A[MSB] ^ bMsbInv;
    assign diffCarryOut = (A[MSB] & bMsbInv) | ((A[MSB] ^ bMsbInv) & diffCarryIn);

`ifdef MY_ALU_MULT_EN
    logic signed [W-1:0] product;
    logic                productOverflow;

    // Operands are sign-extended to W bits, so the W-bit product is exact.
    assign product         = $signed(sextA) * $signed(sextB);
    assign productOverflow = !((&product[W-1:MSB]) || !(|product[W-1:MSB]));
`endif

    my_alu_shifter #(
        .LENGTH (LENGTH)
    ) u_shifter (
        .a       (A),
        .amount  (B),
        .op      (Control),
        .shifted (shifted)
    );

    // Opcode mux and flag selection; anything not decoded yields zero.
    always_comb begin
        resultNext   = '0;
        carryNext    = 1'b0;
        overflowNext = 1'b0;
        case (Control)
            OP_SUM: begin
                resultNext   = sumW;
                carryNext    = sumCarryOut;
                overflowNext = sumCarryOut ^ sumCarryIn;
            end
            OP_SUB: begin
                resultNext   = diffW;
                carryNext    = diffCarryOut;
                overflowNext = diffCarryOut ^ diffCarryIn;
            end
            OP_NEG_B: begin
                resultNext   = negW;
                carryNext    = (B == '0);
                overflowNext = (B == {1'b1, {(LENGTH-1){1'b0}}});
            end
`ifdef MY_ALU_MULT_EN
            OP_MULT: begin
                resultNext   = product;
                overflowNext = productOverflow;
            end
`endif
            OP_AND:     resultNext = zextA & zextB;
            OP_OR:      resultNext = zextA | zextB;
            OP_XOR:     resultNext = zextA ^ zextB;
            OP_NOT_A:   resultNext = {{LENGTH{1'b0}}, ~A};
            OP_SHIFT_L: resultNext = shifted;
            OP_SHIFT_R: resultNext = shifted;
            OP_ASHR:    resultNext = shifted;
            OP_PASS_A:  resultNext = sextA;
            default:    resultNext = '0;
        endcase
    end

    // Output registers: reset wins over enable; disabled cycles hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            Result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (enable) begin
            Result   <= resultNext;
            carry    <= carryNext;
            overflow <= overflowNext;
        end
    end

endmodule

// File: tb/tb_my_alu.sv
// Directed self-checking bench for my_alu at LENGTH = 5.
module tb_my_alu;

    localparam int L = 5;
    localparam int W = 2 * L;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [L-1:0] A;
    logic [L-1:0] B;
    logic [3:0]   Control;
    logic [W-1:0] Result;
    logic         carry;
    logic         overflow;

    int compared;
    int mismatched;

    logic [W+1:0] expv;

    my_alu #(
        .LENGTH (L)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .A        (A),
        .B        (B),
        .Control  (Control),
        .Result   (Result),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, let one rising edge capture it, sample just after.
    task automatic applyStimulus(input logic [L-1:0] a, input logic [L-1:0] b, input logic [3:0] op);
        A       = a;
        B       = b;
        Control = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        enable = 1'b1;
        applyStimulus(5'b11111, 5'b11111, 4'd0);
        rst  = 1'b0;
        expv = {10'b0000000000, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL reset: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_sum;
        applyStimulus(5'b11111, 5'b11111, 4'd0);
        expv = {10'b1111111110, 1'b1, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL sum_m1_m1: got %b expected %b", {Result, carry, overflow}, expv);
        end
        // 15 + 1 = 16 overflows 5-bit signed, no unsigned carry
        applyStimulus(5'b01111, 5'b00001, 4'd0);
        expv = {10'b0000010000, 1'b0, 1'b1};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL sum_ovf: got %b expected %b", {Result, carry, overflow}, expv);
        end
        // -16 + -16 = -32: carry out and signed overflow
        applyStimulus(5'b10000, 5'b10000, 4'd0);
        expv = {10'b1111100000, 1'b1, 1'b1};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL sum_neg_ovf: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_sub;
        applyStimulus(5'b00000, 5'b11111, 4'd1);
        expv = {10'b0000000001, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL sub_0_m1: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b01111, 5'b10000, 4'd1);
        expv = {10'b0000011111, 1'b0, 1'b1};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL sub_ovf: got %b expected %b", {Result, carry, overflow}, expv);
        end
        // 5 - 3 = 2, no borrow so carry = 1
        applyStimulus(5'b00101, 5'b00011, 4'd1);
        expv = {10'b0000000010, 1'b1, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL sub_5_3: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_neg;
        applyStimulus(5'b00000, 5'b00001, 4'd2);
        expv = {10'b1111111111, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL neg_1: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b00000, 5'b10000, 4'd2);
        expv = {10'b0000010000, 1'b0, 1'b1};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL neg_min: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b00000, 4'd2);
        expv = {10'b0000000000, 1'b1, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL neg_0: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_mult;
`ifdef MY_ALU_MULT_EN
        applyStimulus(5'b01111, 5'b01111, 4'd3);
        expv = {10'b0011100001, 1'b0, 1'b1};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL mult_15_15: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10001, 5'b10001, 4'd3);
        expv = {10'b0011100001, 1'b0, 1'b1};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL mult_m15_m15: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b00010, 5'b11101, 4'd3);
        expv = {10'b1111111010, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL mult_2_m3: got %b expected %b", {Result, carry, overflow}, expv);
        end
`else
        applyStimulus(5'b01111, 5'b01111, 4'd3);
        expv = {10'b0000000000, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL mult_disabled: got %b expected %b", {Result, carry, overflow}, expv);
        end
`endif
    endtask

    task automatic test_logic;
        applyStimulus(5'b10101, 5'b01100, 4'd4);
        expv = {10'b0000000100, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL and: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b01100, 4'd5);
        expv = {10'b0000011101, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL or: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b01100, 4'd6);
        expv = {10'b0000011001, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL xor: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b01100, 4'd7);
        expv = {10'b0000001010, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL not_a: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b01100, 4'd11);
        expv = {10'b1111110101, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL pass_a: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_shift;
        applyStimulus(5'b10101, 5'b00010, 4'd8);
        expv = {10'b0001010100, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL shl_2: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b00010, 4'd9);
        expv = {10'b0000000101, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL shr_2: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b00010, 4'd10);
        expv = {10'b1111111101, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL ashr_2: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b01111, 4'd8);
        expv = {10'b0000000000, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL shl_15: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b01111, 4'd10);
        expv = {10'b1111111111, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL ashr_15: got %b expected %b", {Result, carry, overflow}, expv);
        end
        // distance 9 is the last one that keeps a bit of the shifted value
        applyStimulus(5'b00001, 5'b01001, 4'd8);
        expv = {10'b1000000000, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL shl_9: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b10101, 5'b01010, 4'd9);
        expv = {10'b0000000000, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL shr_10: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_reserved;
        applyStimulus(5'b11111, 5'b11111, 4'd13);
        expv = {10'b0000000000, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL reserved_13: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_enable_hold;
        applyStimulus(5'b11111, 5'b11111, 4'd0);
        enable = 1'b0;
        applyStimulus(5'b00001, 5'b00001, 4'd4);
        applyStimulus(5'b01111, 5'b10000, 4'd1);
        expv = {10'b1111111110, 1'b1, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL enable_hold: got %b expected %b", {Result, carry, overflow}, expv);
        end
        enable = 1'b1;
        applyStimulus(5'b01111, 5'b10000, 4'd1);
        expv = {10'b0000011111, 1'b0, 1'b1};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL enable_resume: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    task automatic test_reset_priority;
        rst    = 1'b1;
        enable = 1'b1;
        applyStimulus(5'b01111, 5'b00001, 4'd0);
        rst = 1'b0;
        expv = {10'b0000000000, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got %b expected %b", {Result, carry, overflow}, expv);
        end
        applyStimulus(5'b00011, 5'b00100, 4'd0);
        expv = {10'b0000000111, 1'b0, 1'b0};
        compared++;
        if ({Result, carry, overflow} !== expv) begin
            mismatched++;
            $display("[TB] FAIL after_reset: got %b expected %b", {Result, carry, overflow}, expv);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        A          = '0;
        B          = '0;
        Control    = '0;
        @(negedge clk);
        test_reset();
        test_sum();
        test_sub();
        test_neg();
        test_mult();
        test_logic();
        test_shift();
        test_reserved();
        test_enable_hold();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
